fir_coef_loader: RTL and testbench
==================================

// Module: fir_coef_loader
// PURPOSE
//  Sequences coefficient loads into the fir_filter tap chain. Software writes up to
//  MAX_LEN coefficients into a staging RAM at random addresses, then pulses start.
//  The block then streams them into the filter's cfg_din/cfg_ce shift chain,
//  last-first, so that staged word k lands in tap k+1. It sits between the CPU
//  register bank and fir_filter, and shares the filter's cfg_clk domain.
// PARAMETERS
//  MAX_LEN  64  staging RAM depth; largest filter length the loader accepts
//  COEF_W   25  coefficient width; matches fir_filter cfg_din
//  ADDR_W   6   staging address width; must satisfy 2**ADDR_W >= MAX_LEN
// PORTS
//  clk        in   1       loader clock; connects to fir_filter cfg_clk
//  reset      in   1       asynchronous reset, active-high
//  wr_en      in   1       staging write strobe
//  wr_addr    in   ADDR_W  staging write address (tap index - 1)
//  wr_data    in   COEF_W  signed coefficient to stage
//  wr_rej     out  1       1-cycle pulse: the write was dropped (busy or addr >= MAX_LEN)
//  filt_len   in   32      tap count reported by fir_filter len
//  start      in   1       1-cycle request to load filt_len taps
//  abort      in   1       stops an in-progress load
//  busy       out  1       high from the cycle after an accepted start until done or abort
//  done       out  1       1-cycle pulse: load completed
//  aborted    out  1       1-cycle pulse: load was stopped by abort
//  len_err    out  1       sticky; set when start sees filt_len==0 or filt_len>MAX_LEN
//  cfg_din    out  COEF_W  coefficient to fir_filter
//  cfg_ce     out  1       shift enable to fir_filter
// BEHAVIOUR
//  Reset: async assert; all outputs are 0 and the FSM is in IDLE. Staging RAM
//   contents are not reset. A reset mid-load leaves the filter partially loaded.
//  FSM states: IDLE, PRIME, SHIFT, FIN.
//   IDLE: start with 1<=filt_len<=MAX_LEN latches n=filt_len and rd_addr=n-1,
//    then goes to PRIME. start with a bad len sets len_err and stays in IDLE.
//    len_err clears on the next accepted start.
//   PRIME: one cycle for the synchronous RAM read. Goes to SHIFT. rd_addr decrements.
//   SHIFT: cfg_ce=1 and cfg_din=RAM[n-1-k] on the k-th SHIFT cycle, k=0..n-1.
//    rd_addr decrements each cycle. After n cycles, goes to FIN.
//   FIN: done=1 for one cycle, then returns to IDLE.
//  Timing: start sampled at edge T. cfg_ce is high for cycles T+2 .. T+n+1 and
//   done is high at T+n+2. cfg_ce is never high for more than n cycles per load.
//  cfg_din is registered and is 0 whenever cfg_ce=0.
//  abort in PRIME or SHIFT: the next cycle has cfg_ce=0 and aborted=1, then IDLE.
//   done does not pulse. abort in IDLE or FIN is ignored.
//  If abort and the final SHIFT cycle coincide, abort wins: aborted pulses and
//   done does not. Software must reload.
//  start while busy is ignored and produces no error.
//  Writes: accepted only in IDLE with wr_addr<MAX_LEN; otherwise wr_rej pulses on
//   the next cycle. A write and a start in the same IDLE cycle are both accepted.
//   The write commits before the PRIME read, so the new value is loaded.
//  rd_addr is ADDR_W bits and never wraps; it is not used after the last SHIFT.
// TESTING
//  1 Stage 0..20 with values 100+k, filt_len=21, start -> 21 cfg_ce cycles
//    starting 2 cycles after start, cfg_din=120,119,...,100, done at T+23.
//  2 filt_len=0, then filt_len=65 (MAX_LEN=64), start -> len_err=1, no cfg_ce,
//    busy=0. A valid start then clears len_err.
//  3 abort on the 5th SHIFT cycle of a 21-tap load -> cfg_ce=0 next cycle,
//    aborted pulse, no done, exactly 5 cfg_ce cycles total.
//  4 wr_en during busy, and wr_addr=64 in IDLE -> wr_rej pulses, and the RAM is
//    unchanged (confirmed by a later load).
//  5 Assert reset asynchronously at SHIFT k=7 -> all outputs 0 immediately.
//    A subsequent start runs a full, correct load.
//  6 filt_len=1 -> one cfg_ce with cfg_din=RAM[0]. Same-cycle wr_en(addr 0,
//    value -5)+start -> cfg_din=-5.

Source files
------------

// File: rtl/fir_coef_loader_if.sv
// Bus between the CPU register bank, the coefficient loader and the fir_filter config chain.
// The master side is the CPU and filter view; the slave side is the loader.
interface fir_coef_loader_if #(
    parameter int unsigned COEF_W = 25,
    parameter int unsigned ADDR_W = 6
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [COEF_W-1:0] wr_data;
    logic              wr_rej;
    logic [31:0]       filt_len;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              len_err;
    logic [COEF_W-1:0] cfg_din;
    logic              cfg_ce;

    modport master (
        output wr_en, wr_addr, wr_data, filt_len, start, abort,
        input  wr_rej, busy, done, aborted, len_err, cfg_din, cfg_ce
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, filt_len, start, abort,
        output wr_rej, busy, done, aborted, len_err, cfg_din, cfg_ce
    );
endinterface

// File: rtl/fir_coef_loader.sv
// Stages fir_filter coefficients in a RAM and shifts them into the filter's config chain,
// last word first, so that staged word k ends up in tap k+1.
module fir_coef_loader #(
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned COEF_W  = 25,
    parameter int unsigned ADDR_W  = 6
) (
    input logic              clk,
    input logic              reset,
    fir_coef_loader_if.slave bus
);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned RAM_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {StIdle, StPrime, StShift, StFin} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] rd_addr_dec;
    logic [COEF_W-1:0] cfg_din_q, cfg_din_d;
    logic              aborted_q, aborted_d;
    logic              len_err_q, len_err_d;
    logic              wr_rej_q, wr_rej_d;
    logic              wr_ok;
    logic              len_ok;
    logic [COEF_W-1:0] ram_rd;

    logic [COEF_W-1:0] ram [MAX_LEN];

    assign len_ok = (bus.filt_len != 32'd0) && (bus.filt_len <= MAX_LEN);
    assign wr_ok  = bus.wr_en && (state_q == StIdle) && (32'(bus.wr_addr) < MAX_LEN);

    // Staging RAM has no reset; contents survive a reset mid-load.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            ram[bus.wr_addr[RAM_AW-1:0]] <= bus.wr_data;
        end
    end

    assign ram_rd      = ram[rd_addr_q[RAM_AW-1:0]];
    assign rd_addr_dec = (rd_addr_q != '0) ? rd_addr_q - 1'b1 : rd_addr_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        cfg_din_d = '0;
        aborted_d = 1'b0;
        len_err_d = len_err_q;
        wr_rej_d  = bus.wr_en && !wr_ok;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (len_ok) begin
                        len_d     = CNT_W'(bus.filt_len);
                        rd_addr_d = ADDR_W'(bus.filt_len - 32'd1);
                        cnt_d     = '0;
                        len_err_d = 1'b0;
                        state_d   = StPrime;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            StPrime: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cfg_din_d = ram_rd;
                    rd_addr_d = rd_addr_dec;
                    state_d   = StShift;
                end
            end
            StShift: begin
                // Abort wins over the final shift, so a clipped load never reports done.
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = StIdle;
                end else if (cnt_q == len_q - 1'b1) begin
                    state_d = StFin;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    cfg_din_d = ram_rd;
                    rd_addr_d = rd_addr_dec;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            len_q     <= '0;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            cfg_din_q <= '0;
            aborted_q <= 1'b0;
            len_err_q <= 1'b0;
            wr_rej_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            rd_addr_q <= rd_addr_d;
            cfg_din_q <= cfg_din_d;
            aborted_q <= aborted_d;
            len_err_q <= len_err_d;
            wr_rej_q  <= wr_rej_d;
        end
    end

    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = (state_q == StFin);
    assign bus.cfg_ce  = (state_q == StShift);
    assign bus.cfg_din = cfg_din_q;
    assign bus.aborted = aborted_q;
    assign bus.len_err = len_err_q;
    assign bus.wr_rej  = wr_rej_q;
endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader: a table of load scenarios plus a reset-mid-load sequence, with a
// scoreboard queue of expected cfg_din words consumed whenever cfg_ce is high.
module tb_fir_coef_loader;
    localparam int unsigned MAX_LEN = 64;
    localparam int unsigned COEF_W  = 25;
    localparam int unsigned ADDR_W  = 7;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fir_coef_loader_if #(.COEF_W(COEF_W), .ADDR_W(ADDR_W)) bus ();

    fir_coef_loader #(
        .MAX_LEN(MAX_LEN),
        .COEF_W (COEF_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int len;
        int abort_k;   // 0: none, 255: abort in PRIME, else abort on that SHIFT cycle
        bit wr_busy;
        bit wr_same;
        int exp_ce;
        bit exp_done;
        bit exp_ab;
        bit exp_lerr;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [COEF_W-1:0] model [MAX_LEN];
    logic [COEF_W-1:0] sb [$];
    logic [COEF_W-1:0] mon_exp;
    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.cfg_ce) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cfg_ce_extra: got cfg_din %0h expected no shift", bus.cfg_din);
                end else begin
                    mon_exp = sb.pop_front();
                    chk("cfg_din", 32'(bus.cfg_din), 32'(mon_exp));
                end
            end else begin
                chk("cfg_din_idle", 32'(bus.cfg_din), 32'd0);
            end
        end
    end

    task automatic stage(input logic [ADDR_W-1:0] addr, input logic [COEF_W-1:0] data,
                         input bit exp_rej);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en = 1'b0;
        chk($sformatf("wr_rej_a%0d", addr), 32'(bus.wr_rej), 32'(exp_rej));
        if (!exp_rej) model[addr[5:0]] = data;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int shifts   = 0;
        int done_idx = -1;
        bit ab_seen  = 1'b0;
        bit wr_pend  = 1'b0;
        bit aborting = 1'b0;
        bit valid;
        valid = (v.len >= 1) && (v.len <= int'(MAX_LEN));
        @(negedge clk);
        bus.filt_len = 32'(v.len);
        bus.start    = 1'b1;
        if (v.wr_same) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = '0;
            bus.wr_data = COEF_W'(-5);
            model[0]    = COEF_W'(-5);
        end
        if (valid) for (int k = v.len - 1; k >= 0; k--) sb.push_back(model[k]);
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        chk($sformatf("v%0d_busy_start", id), 32'(bus.busy), 32'(valid));
        chk($sformatf("v%0d_len_err", id), 32'(bus.len_err), 32'(v.exp_lerr));
        chk($sformatf("v%0d_ce_prime", id), 32'(bus.cfg_ce), 32'd0);
        if (v.wr_same) chk($sformatf("v%0d_wr_rej_same", id), 32'(bus.wr_rej), 32'd0);
        if (v.abort_k == 255) begin
            bus.abort = 1'b1;
            aborting  = 1'b1;
        end
        for (int i = 1; i <= (valid ? 150 : 6); i++) begin
            @(negedge clk);
            if (wr_pend) begin
                chk($sformatf("v%0d_wr_rej_busy", id), 32'(bus.wr_rej), 32'd1);
                bus.wr_en = 1'b0;
                wr_pend   = 1'b0;
            end
            if (aborting) begin
                bus.abort = 1'b0;
                chk($sformatf("v%0d_ce_after_abort", id), 32'(bus.cfg_ce), 32'd0);
                chk($sformatf("v%0d_aborted_pulse", id), 32'(bus.aborted), 32'd1);
                chk($sformatf("v%0d_done_on_abort", id), 32'(bus.done), 32'd0);
                ab_seen = 1'b1;
                break;
            end
            if (bus.done) begin
                done_idx = i;
                break;
            end
            if (bus.cfg_ce) shifts++;
            if (v.wr_busy && i == 2) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 7'd3;
                bus.wr_data = 25'd12345;
                wr_pend     = 1'b1;
            end
            if (v.abort_k > 0 && v.abort_k != 255 && bus.cfg_ce && shifts == v.abort_k) begin
                bus.abort = 1'b1;
                aborting  = 1'b1;
            end
        end
        bus.wr_en = 1'b0;
        bus.abort = 1'b0;
        chk($sformatf("v%0d_shift_count", id), 32'(shifts), 32'(v.exp_ce));
        chk($sformatf("v%0d_done_seen", id), 32'(done_idx >= 0), 32'(v.exp_done));
        if (v.exp_done) chk($sformatf("v%0d_done_time", id), 32'(done_idx), 32'(v.len + 1));
        chk($sformatf("v%0d_aborted_seen", id), 32'(ab_seen), 32'(v.exp_ab));
        if (!v.exp_ab) chk($sformatf("v%0d_sb_drained", id), 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clk);
        chk($sformatf("v%0d_busy_end", id), 32'(bus.busy), 32'd0);
        chk($sformatf("v%0d_done_end", id), 32'(bus.done), 32'd0);
        chk($sformatf("v%0d_aborted_end", id), 32'(bus.aborted), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_aborted"}, 32'(bus.aborted), 32'd0);
        chk({tag, "_len_err"}, 32'(bus.len_err), 32'd0);
        chk({tag, "_cfg_ce"}, 32'(bus.cfg_ce), 32'd0);
        chk({tag, "_cfg_din"}, 32'(bus.cfg_din), 32'd0);
        chk({tag, "_wr_rej"}, 32'(bus.wr_rej), 32'd0);
    endtask

    initial begin
        vec_t rv;
        int   shifts;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.filt_len = '0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        reset        = 1'b1;

        vecs.push_back('{21,  0,   0, 0, 21, 1, 0, 0});
        vecs.push_back('{0,   0,   0, 0, 0,  0, 0, 1});
        vecs.push_back('{65,  0,   0, 0, 0,  0, 0, 1});
        vecs.push_back('{21,  0,   1, 0, 21, 1, 0, 0});
        vecs.push_back('{21,  5,   0, 0, 5,  0, 1, 0});
        vecs.push_back('{3,   3,   0, 0, 3,  0, 1, 0});
        vecs.push_back('{21,  255, 0, 0, 0,  0, 1, 0});
        vecs.push_back('{64,  0,   0, 0, 64, 1, 0, 0});
        vecs.push_back('{1,   0,   0, 0, 1,  1, 0, 0});
        vecs.push_back('{1,   0,   0, 1, 1,  1, 0, 0});
        vecs.push_back('{2,   0,   0, 0, 2,  1, 0, 0});

        repeat (3) @(negedge clk);
        chk_outputs_zero("in_reset");
        reset = 1'b0;
        @(negedge clk);
        chk_outputs_zero("after_reset");

        for (int k = 0; k < int'(MAX_LEN); k++) begin
            stage(ADDR_W'(k), (k <= 20) ? COEF_W'(100 + k) : COEF_W'($urandom), 1'b0);
        end
        stage(7'd64, 25'd777, 1'b1);
        stage(7'd100, 25'd777, 1'b1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset asserted asynchronously during the 8th shift (k=7).
        @(negedge clk);
        bus.filt_len = 32'd21;
        bus.start    = 1'b1;
        for (int k = 20; k >= 0; k--) sb.push_back(model[k]);
        @(negedge clk);
        bus.start = 1'b0;
        shifts    = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.cfg_ce) shifts++;
            if (shifts == 8) break;
        end
        chk("reset_reach_k7", 32'(shifts), 32'd8);
        #2;
        reset = 1'b1;
        #1;
        chk_outputs_zero("mid_load_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        rv = '{21, 0, 0, 0, 21, 1, 0, 0};
        run_vec(rv, 99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
